// File: rtl/uart_imem_loader.sv
// Boot-time program loader: packs UART bytes (LSB first) into 32-bit words,
// writes them to consecutive instruction-memory addresses, stops on an
// end-of-program marker and then releases the core from reset. Partial words
// are abandoned on an inter-byte timeout or a UART BREAK.
module uart_imem_loader #(
   parameter int          ADDR_W         = 8,
   parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYCLES = 200000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              uart_rx_valid,
   input  logic [7:0]        uart_rx_data,
   input  logic              uart_rx_break,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              write_done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count,
   output logic              core_resetn
);

   localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [1:0]        bidx_r;
   logic [31:0]       word_r;
   logic [IDLE_W-1:0] idle_r;

   logic              accept_s;
   logic              brk_s;
   logic              timeout_s;
   logic              last_byte_s;
   logic [31:0]       word_s;
   logic              is_end_s;
   logic              is_full_s;
   logic              we_nxt_s;
   logic              set_done_s;
   logic              set_ovf_s;

   // Qualify UART events; break beats a simultaneous byte, a byte beats an expiring timeout.
   always_comb begin
      brk_s       = (state_r == ST_LOAD) && uart_rx_break;
      accept_s    = (state_r == ST_LOAD) && uart_rx_valid && !uart_rx_break;
      timeout_s   = (state_r == ST_LOAD) && (bidx_r != 2'd0) && !uart_rx_valid &&
                    !uart_rx_break && (idle_r == IDLE_LAST);
      last_byte_s = accept_s && (bidx_r == 2'd3);
      word_s      = {uart_rx_data, word_r[23:0]};
      is_end_s    = (word_s == END_WORD);
      is_full_s   = (word_count == CAPACITY);
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_LOAD;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decision: a completed word either ends the load or is written.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_LOAD: begin
            if (last_byte_s) begin
               if (is_end_s || is_full_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_WRITE;
               end
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_WRITE: state_nxt_s = ST_LOAD;
         ST_DONE:  state_nxt_s = ST_DONE;
         default:  state_nxt_s = ST_LOAD;
      endcase
   end

   // Output decode: what the registered outputs must do on the coming edge.
   always_comb begin
      we_nxt_s   = 1'b0;
      set_done_s = 1'b0;
      set_ovf_s  = 1'b0;
      case (state_r)
         ST_LOAD: begin
            if (last_byte_s) begin
               if (is_end_s) begin
                  set_done_s = 1'b1;
               end else if (is_full_s) begin
                  set_done_s = 1'b1;
                  set_ovf_s  = 1'b1;
               end else begin
                  we_nxt_s   = 1'b1;
               end
            end else begin
               we_nxt_s = 1'b0;
            end
         end
         default: begin
            we_nxt_s   = 1'b0;
            set_done_s = 1'b0;
            set_ovf_s  = 1'b0;
         end
      endcase
   end

   // Byte assembly and inter-byte idle counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bidx_r <= 2'd0;
         word_r <= 32'd0;
         idle_r <= {IDLE_W{1'b0}};
      end else begin
         case (state_r)
            ST_LOAD: begin
               if (brk_s) begin
                  bidx_r <= 2'd0;
                  idle_r <= {IDLE_W{1'b0}};
               end else if (accept_s) begin
                  word_r[{bidx_r, 3'b000} +: 8] <= uart_rx_data;
                  bidx_r <= bidx_r + 2'd1;
                  idle_r <= {IDLE_W{1'b0}};
               end else if (timeout_s) begin
                  bidx_r <= 2'd0;
                  idle_r <= {IDLE_W{1'b0}};
               end else if (bidx_r != 2'd0) begin
                  idle_r <= idle_r + IDLE_W'(1);
               end else begin
                  idle_r <= {IDLE_W{1'b0}};
               end
            end
            default: begin
               bidx_r <= 2'd0;
               idle_r <= {IDLE_W{1'b0}};
            end
         endcase
      end
   end

   // Registered memory-write port, word counter and sticky status flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         imem_we     <= 1'b0;
         imem_addr   <= {ADDR_W{1'b0}};
         imem_wdata  <= 32'd0;
         write_done  <= 1'b0;
         overflow    <= 1'b0;
         word_count  <= {(ADDR_W+1){1'b0}};
         core_resetn <= 1'b0;
      end else begin
         imem_we <= we_nxt_s;
         if (we_nxt_s) begin
            imem_addr  <= word_count[ADDR_W-1:0];
            imem_wdata <= word_s;
         end
         if (state_r == ST_WRITE) begin
            word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
         end
         write_done  <= write_done | set_done_s;
         overflow    <= overflow | set_ovf_s;
         core_resetn <= write_done;
      end
   end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader: directed vector table, hand-written corner
// sequences and randomized traffic checked against a byte-level reference model.
module tb_uart_imem_loader;

   localparam int AW  = 2;
   localparam int T   = 40;
   localparam int CAP = 4;

   logic          clk = 1'b0;
   logic          resetn;
   logic          uart_rx_valid;
   logic [7:0]    uart_rx_data;
   logic          uart_rx_break;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          write_done;
   logic          overflow;
   logic [AW:0]   word_count;
   logic          core_resetn;

   uart_imem_loader #(.ADDR_W(AW), .END_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .resetn(resetn),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .write_done(write_done), .overflow(overflow), .word_count(word_count),
      .core_resetn(core_resetn)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // expected memory writes
   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;
   wr_t sb[$];

   // reference model state
   int          m_n;
   int          m_last;
   int          m_wcyc;
   int          m_count;
   logic [31:0] m_word;
   bit          m_done;
   bit          m_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor: every write strobe must match the model's next expected write
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("wr_missing_cycle", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         chk("wr_we", imem_we, 1);
         chk("wr_addr", imem_addr, sb[0].addr);
         chk("wr_data", imem_wdata, sb[0].data);
         void'(sb.pop_front());
      end else if (imem_we) begin
         chk("spurious_we", imem_we, 0);
      end
   end

   task automatic model_reset();
      m_n = 0; m_last = 0; m_wcyc = -1; m_count = 0;
      m_word = 32'd0; m_done = 1'b0; m_ovf = 1'b0;
      sb.delete();
   endtask

   // Byte-level rules: break drops the partial word, a byte more than T cycles
   // after the previous one starts a fresh word, a byte in the write cycle is lost.
   task automatic model_event(input bit v, input bit b, input logic [7:0] d);
      int c;
      c = cyc;
      if (m_done) return;
      if (b) begin
         m_n = 0;
         m_word = 32'd0;
      end else if (v && c != m_wcyc) begin
         if (m_n > 0 && (c - m_last) > T) begin
            m_n = 0;
            m_word = 32'd0;
         end
         m_word = m_word | (32'(d) << (8 * m_n));
         m_n++;
         m_last = c;
         if (m_n == 4) begin
            m_n = 0;
            if (m_word == 32'hFFFF_FFFF) begin
               m_done = 1'b1;
            end else if (m_count == CAP) begin
               m_done = 1'b1;
               m_ovf = 1'b1;
            end else begin
               sb.push_back('{c + 1, AW'(m_count), m_word});
               m_count++;
               m_wcyc = c + 1;
            end
            m_word = 32'd0;
         end
      end
   endtask

   task automatic step(input bit v, input bit b, input logic [7:0] d);
      uart_rx_valid = v;
      uart_rx_break = b;
      uart_rx_data  = d;
      model_event(v, b, d);
      @(negedge clk);
      #1;
      uart_rx_valid = 1'b0;
      uart_rx_break = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, w[8*i +: 8]);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      uart_rx_valid = 1'b0;
      uart_rx_break = 1'b0;
      uart_rx_data  = 8'h00;
      model_reset();
      #2;
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_done", write_done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_count", word_count, 0);
      chk("rst_core", core_resetn, 0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
   endtask

   typedef struct {
      logic [31:0]   w;
      bit            exp_we;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_data;
      bit            exp_done;
      int            exp_count;
   } vec_t;
   vec_t vt[5];

   initial begin
      logic [7:0] rb;
      int         g;
      int         r;

      vt[0] = '{32'hFB01_0113, 1'b1, 2'd0, 32'hFB01_0113, 1'b0, 1};
      vt[1] = '{32'h0481_2623, 1'b1, 2'd1, 32'h0481_2623, 1'b0, 2};
      vt[2] = '{32'hFF70_0793, 1'b1, 2'd2, 32'hFF70_0793, 1'b0, 3};
      vt[3] = '{32'hFFFF_FFFF, 1'b0, 2'd2, 32'hFF70_0793, 1'b1, 3};
      vt[4] = '{32'hFFFF_FFFF, 1'b0, 2'd2, 32'hFF70_0793, 1'b1, 3};

      resetn = 1'b0;
      uart_rx_valid = 1'b0;
      uart_rx_break = 1'b0;
      uart_rx_data  = 8'h00;
      @(negedge clk);
      #1;
      do_reset();

      // table: three program words, then two end markers
      for (int i = 0; i < 5; i++) begin
         send_word(vt[i].w);
         chk("tbl_we", imem_we, vt[i].exp_we);
         chk("tbl_addr", imem_addr, vt[i].exp_addr);
         chk("tbl_wdata", imem_wdata, vt[i].exp_data);
         chk("tbl_done", write_done, vt[i].exp_done);
         chk("tbl_core_n1", core_resetn, (i > 0) ? vt[i-1].exp_done : 1'b0);
         idle(1);
         chk("tbl_count", word_count, vt[i].exp_count);
         chk("tbl_core_n2", core_resetn, vt[i].exp_done);
         chk("tbl_ovf", overflow, 0);
      end

      // timeout discards a 2-byte partial word
      do_reset();
      step(1'b1, 1'b0, 8'h13);
      step(1'b1, 1'b0, 8'h01);
      idle(T + 10);
      send_word(32'hFF70_0793);
      idle(2);
      chk("to_count", word_count, 1);
      chk("to_addr", imem_addr, 0);
      chk("to_wdata", imem_wdata, 32'hFF70_0793);

      // byte arriving in the expiring cycle is kept
      do_reset();
      step(1'b1, 1'b0, 8'h13);
      idle(T - 1);
      step(1'b1, 1'b0, 8'h01);
      step(1'b1, 1'b0, 8'h01);
      step(1'b1, 1'b0, 8'hFB);
      idle(2);
      chk("to_edge_count", word_count, 1);
      chk("to_edge_wdata", imem_wdata, 32'hFB01_0113);

      // one cycle later the partial byte is gone
      do_reset();
      step(1'b1, 1'b0, 8'hAA);
      idle(T);
      send_word(32'hFB01_0113);
      idle(2);
      chk("to_late_count", word_count, 1);
      chk("to_late_wdata", imem_wdata, 32'hFB01_0113);

      // break together with a byte drops the partial word and the byte
      do_reset();
      step(1'b1, 1'b0, 8'h13);
      step(1'b1, 1'b0, 8'h01);
      step(1'b1, 1'b0, 8'h01);
      step(1'b1, 1'b1, 8'h55);
      send_word(32'h0481_2623);
      idle(2);
      chk("brk_count", word_count, 1);
      chk("brk_addr", imem_addr, 0);
      chk("brk_wdata", imem_wdata, 32'h0481_2623);

      // capacity overflow on the fifth word
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_word(32'h1000_0000 + 32'(i));
         idle(1);
      end
      chk("ovf_count4", word_count, 4);
      send_word(32'h1000_0004);
      chk("ovf_we", imem_we, 0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_done", write_done, 1);
      idle(1);
      chk("ovf_count_hold", word_count, 4);
      chk("ovf_core", core_resetn, 1);
      chk("ovf_addr_hold", imem_addr, 3);

      // reset in the middle of a word
      do_reset();
      step(1'b1, 1'b0, 8'h13);
      step(1'b1, 1'b0, 8'h01);
      do_reset();
      send_word(32'h0481_2623);
      idle(2);
      chk("mid_rst_count", word_count, 1);
      chk("mid_rst_addr", imem_addr, 0);
      chk("mid_rst_wdata", imem_wdata, 32'h0481_2623);

      // randomized traffic against the reference model
      for (int seg = 0; seg < 25; seg++) begin
         do_reset();
         for (int e = 0; e < 40; e++) begin
            case ($urandom_range(0, 7))
               0: g = 0;
               1: g = 1;
               2: g = 2;
               3: g = T - 2;
               4: g = T - 1;
               5: g = T;
               6: g = T + 1;
               default: g = 3;
            endcase
            if ($urandom_range(0, 3) == 0) g = 0;
            idle(g);
            r  = int'($urandom_range(0, 11));
            rb = 8'($urandom);
            if ((seg % 3) == 0) begin
               if ($urandom_range(0, 3) != 0) rb = 8'hFF;
            end else begin
               if ($urandom_range(0, 7) == 0) rb = 8'hFF;
            end
            if (r == 0) step(1'b0, 1'b1, rb);
            else if (r == 1) step(1'b1, 1'b1, rb);
            else step(1'b1, 1'b0, rb);
         end
         idle(3);
         chk("rnd_count", word_count, m_count);
         chk("rnd_done", write_done, m_done);
         chk("rnd_ovf", overflow, m_ovf);
         chk("rnd_core", core_resetn, m_done);
         chk("rnd_pending", sb.size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
